// File: rtl/i2s_sample_feeder_if.sv
// ============================================================================
// Module   : i2s_sample_feeder_if
// Brief    : Producer-side and transmitter-side signal bundle for the feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_sample_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_mute;
  logic             i_clear_underrun;
  logic [WIDTH-1:0] o_sample;
  logic             o_chan;
  logic [LW-1:0]    o_level;
  logic             o_playing;
  logic             o_underrun;

  modport master (
    output i_data, i_valid, i_mute, i_clear_underrun,
    input  o_ready, o_sample, o_chan, o_level, o_playing, o_underrun
  );

  modport slave (
    input  i_data, i_valid, i_mute, i_clear_underrun,
    output o_ready, o_sample, o_chan, o_level, o_playing, o_underrun
  );
endinterface

`default_nettype wire

// File: rtl/i2s_sample_feeder.sv
// ============================================================================
// Module   : i2s_sample_feeder
// Brief    : FIFO-buffered L/R sample feeder, phase-locked to the I2S frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sample_feeder #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PREFILL   = 8,
  parameter int UPDATE_AT = 0
) (
  input  logic               clk,
  input  logic               resetn,
  i2s_sample_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] c_depth   = LW'(DEPTH);
  localparam logic [LW-1:0] c_prefill = LW'(PREFILL);
  localparam logic [6:0]    c_update  = 7'(UPDATE_AT);

  localparam logic [0:0] c_st_wait = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  logic [7:0]       r_cnt;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sample;
  logic             r_chan;
  logic             r_underrun;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_slot;
  logic             w_ready;
  logic             w_push;
  logic             w_start;
  logic             w_starve;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  assign w_slot   = (r_cnt[6:0] == c_update);
  assign w_ready  = (r_level < c_depth);
  assign w_push   = bus.i_valid & w_ready;
  // Playback (re)starts only on a left slot so L/R pairing survives underruns
  assign w_start  = w_slot & (r_state == c_st_wait) & ~r_cnt[7] & (r_level >= c_prefill);
  assign w_starve = w_slot & (r_state == c_st_run) & (r_level == '0);
  assign w_pop    = w_start | (w_slot & (r_state == c_st_run) & (r_level != '0));
  assign w_head   = r_mem[r_rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_st_wait;
    end else if (w_start) begin
      r_state <= c_st_run;
    end else if (w_starve) begin
      r_state <= c_st_wait;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sample <= '0;
      r_chan   <= 1'b0;
    end else if (w_slot) begin
      r_chan <= r_cnt[7];
      if (w_pop && !bus.i_mute) begin
        r_sample <= w_head;
      end else begin
        r_sample <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_underrun <= 1'b0;
    end else if (w_starve) begin
      r_underrun <= 1'b1;
    end else if (bus.i_clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_sample   = r_sample;
  assign bus.o_chan     = r_chan;
  assign bus.o_level    = r_level;
  assign bus.o_playing  = (r_state == c_st_run);
  assign bus.o_underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_sample_feeder.sv
// ============================================================================
// Module   : tb_i2s_sample_feeder
// Brief    : Directed self-checking bench for i2s_sample_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_sample_feeder;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   asserts = 0;
  int   errors  = 0;
  logic [7:0] tcnt;

  always #5 clk = ~clk;

  i2s_sample_feeder_if #(.WIDTH(8), .DEPTH(16)) bus ();

  i2s_sample_feeder #(
    .WIDTH(8), .DEPTH(16), .PREFILL(8), .UPDATE_AT(0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // Reference frame position, counted independently from reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt <= '0;
    else         tcnt <= tcnt + 1'b1;
  end

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_mute = 1'b0;
    bus.i_clear_underrun = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.i_data = d;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    @(negedge clk);
    while (int'(tcnt) != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (int'(tcnt) != v) begin
      asserts++; errors++;
      $display("FAIL wait_cnt_timeout: counter %0d want %0d", tcnt, v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (1024) @(negedge clk);
    asserts++; if (bus.o_sample !== 8'h00) begin errors++; $display("FAIL reset_sample: got %h want 00", bus.o_sample); end
    asserts++; if (bus.o_playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", bus.o_playing); end
    asserts++; if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.o_underrun); end
    asserts++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.o_level); end
    asserts++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
  endtask

  task automatic test_playback();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
    asserts++; if (bus.o_playing !== 1'b0) begin errors++; $display("FAIL pb_prefill_playing: got %b want 0", bus.o_playing); end
    wait_cnt(1);
    asserts++; if (bus.o_sample !== 8'h11) begin errors++; $display("FAIL pb_left1_sample: got %h want 11", bus.o_sample); end
    asserts++; if (bus.o_chan !== 1'b0) begin errors++; $display("FAIL pb_left1_chan: got %b want 0", bus.o_chan); end
    asserts++; if (bus.o_level !== 5'd7) begin errors++; $display("FAIL pb_left1_level: got %0d want 7", bus.o_level); end
    asserts++; if (bus.o_playing !== 1'b1) begin errors++; $display("FAIL pb_left1_playing: got %b want 1", bus.o_playing); end
    wait_cnt(4);
    asserts++; if (bus.o_sample !== 8'h11) begin errors++; $display("FAIL pb_load_stable: got %h want 11", bus.o_sample); end
    wait_cnt(128);
    asserts++; if (bus.o_sample !== 8'h11) begin errors++; $display("FAIL pb_pre_right: got %h want 11", bus.o_sample); end
    wait_cnt(129);
    asserts++; if (bus.o_sample !== 8'h22) begin errors++; $display("FAIL pb_right1_sample: got %h want 22", bus.o_sample); end
    asserts++; if (bus.o_chan !== 1'b1) begin errors++; $display("FAIL pb_right1_chan: got %b want 1", bus.o_chan); end
    asserts++; if (bus.o_level !== 5'd6) begin errors++; $display("FAIL pb_right1_level: got %0d want 6", bus.o_level); end
    wait_cnt(1);
    asserts++; if (bus.o_sample !== 8'h33) begin errors++; $display("FAIL pb_left2_sample: got %h want 33", bus.o_sample); end
    asserts++; if (bus.o_level !== 5'd5) begin errors++; $display("FAIL pb_left2_level: got %0d want 5", bus.o_level); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
    asserts++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.o_ready); end
    asserts++; if (bus.o_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", bus.o_level); end
    push(8'hFF);
    asserts++; if (bus.o_level !== 5'd16) begin errors++; $display("FAIL full_overflow_level: got %0d want 16", bus.o_level); end
    wait_cnt(1);
    asserts++; if (bus.o_level !== 5'd15) begin errors++; $display("FAIL full_pop_level: got %0d want 15", bus.o_level); end
    asserts++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", bus.o_ready); end
    asserts++; if (bus.o_sample !== 8'hA0) begin errors++; $display("FAIL full_pop_sample: got %h want a0", bus.o_sample); end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
    repeat (4) begin
      wait_cnt(1);
      wait_cnt(129);
    end
    asserts++; if (bus.o_sample !== 8'h88) begin errors++; $display("FAIL ur_last_sample: got %h want 88", bus.o_sample); end
    asserts++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL ur_last_level: got %0d want 0", bus.o_level); end
    wait_cnt(0);
    bus.i_clear_underrun = 1'b1;
    @(negedge clk);
    bus.i_clear_underrun = 1'b0;
    asserts++; if (bus.o_underrun !== 1'b1) begin errors++; $display("FAIL ur_flag_priority: got %b want 1", bus.o_underrun); end
    asserts++; if (bus.o_playing !== 1'b0) begin errors++; $display("FAIL ur_playing: got %b want 0", bus.o_playing); end
    asserts++; if (bus.o_sample !== 8'h00) begin errors++; $display("FAIL ur_sample: got %h want 00", bus.o_sample); end
    bus.i_clear_underrun = 1'b1;
    @(negedge clk);
    bus.i_clear_underrun = 1'b0;
    asserts++; if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b want 0", bus.o_underrun); end
    wait_cnt(140);
    for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
    wait_cnt(200);
    asserts++; if (bus.o_playing !== 1'b0) begin errors++; $display("FAIL refill_wait_playing: got %b want 0", bus.o_playing); end
    asserts++; if (bus.o_level !== 5'd8) begin errors++; $display("FAIL refill_wait_level: got %0d want 8", bus.o_level); end
    wait_cnt(1);
    asserts++; if (bus.o_playing !== 1'b1) begin errors++; $display("FAIL refill_playing: got %b want 1", bus.o_playing); end
    asserts++; if (bus.o_chan !== 1'b0) begin errors++; $display("FAIL refill_chan: got %b want 0", bus.o_chan); end
    asserts++; if (bus.o_sample !== 8'h31) begin errors++; $display("FAIL refill_sample: got %h want 31", bus.o_sample); end
  endtask

  task automatic test_mute();
    logic [7:0] vals [8];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hA5, 8'h77, 8'h88};
    do_reset();
    for (int i = 0; i < 8; i++) push(vals[i]);
    wait_cnt(1); wait_cnt(129); wait_cnt(1); wait_cnt(129);
    asserts++; if (bus.o_sample !== 8'h44) begin errors++; $display("FAIL mute_pre_sample: got %h want 44", bus.o_sample); end
    bus.i_mute = 1'b1;
    wait_cnt(1);
    asserts++; if (bus.o_sample !== 8'h00) begin errors++; $display("FAIL mute_left_sample: got %h want 00", bus.o_sample); end
    asserts++; if (bus.o_level !== 5'd3) begin errors++; $display("FAIL mute_left_level: got %0d want 3", bus.o_level); end
    wait_cnt(129);
    asserts++; if (bus.o_sample !== 8'h00) begin errors++; $display("FAIL mute_right_sample: got %h want 00", bus.o_sample); end
    asserts++; if (bus.o_level !== 5'd2) begin errors++; $display("FAIL mute_right_level: got %0d want 2", bus.o_level); end
    bus.i_mute = 1'b0;
    wait_cnt(1);
    asserts++; if (bus.o_sample !== 8'h77) begin errors++; $display("FAIL unmute_sample: got %h want 77", bus.o_sample); end
    asserts++; if (bus.o_chan !== 1'b0) begin errors++; $display("FAIL unmute_chan: got %b want 0", bus.o_chan); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
    wait_cnt(1);
    wait_cnt(180);
    asserts++; if (bus.o_sample !== 8'h22 || bus.o_chan !== 1'b1) begin errors++; $display("FAIL arst_pre: got %h/%b want 22/1", bus.o_sample, bus.o_chan); end
    resetn = 1'b0;
    #1;
    asserts++; if (bus.o_sample !== 8'h00) begin errors++; $display("FAIL arst_sample: got %h want 00", bus.o_sample); end
    asserts++; if (bus.o_chan !== 1'b0) begin errors++; $display("FAIL arst_chan: got %b want 0", bus.o_chan); end
    asserts++; if (bus.o_playing !== 1'b0) begin errors++; $display("FAIL arst_playing: got %b want 0", bus.o_playing); end
    asserts++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", bus.o_level); end
    asserts++; if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL arst_underrun: got %b want 0", bus.o_underrun); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    asserts++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", bus.o_ready); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_mute = 1'b0;
    bus.i_clear_underrun = 1'b0;
    test_reset();
    test_playback();
    test_full();
    test_underrun();
    test_mute();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule

`default_nettype wire
